// File: rtl/rf_pkg.sv
// Shared register-file constants and the architectural register address type
// used by the decode and writeback stages.
package rf_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_NUM_REG    = 32;
  localparam int unsigned REG_ADDR_W         = $clog2(DEFAULT_NUM_REG);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Write, reservation and read-port bundle of the register file.
interface reg_file_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_REG    = DEFAULT_NUM_REG,
  parameter int unsigned NUM_READ   = 2
);

  localparam int unsigned ADDR_W = $clog2(NUM_REG);

  logic                         i_write_enable;
  logic [ADDR_W-1:0]            i_write_addr;
  logic [DATA_WIDTH-1:0]        i_write_data;
  logic                         i_reserve_enable;
  logic [ADDR_W-1:0]            i_reserve_addr;
  logic [NUM_READ*ADDR_W-1:0]   i_read_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] o_read_data;
  logic [NUM_READ-1:0]          o_read_busy;
  logic [NUM_REG-1:0]           o_pending;

  modport master (
    output i_write_enable, i_write_addr, i_write_data,
    output i_reserve_enable, i_reserve_addr, i_read_addr,
    input  o_read_data, o_read_busy, o_pending
  );

  modport slave (
    input  i_write_enable, i_write_addr, i_write_data,
    input  i_reserve_enable, i_reserve_addr, i_read_addr,
    output o_read_data, o_read_busy, o_pending
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set by a reservation,
// cleared by a write; a same-cycle reservation beats the clear.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REG = DEFAULT_NUM_REG,
  parameter int unsigned ADDR_W  = $clog2(NUM_REG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [ADDR_W-1:0]  set_addr,
  input  logic               clr_en,
  input  logic [ADDR_W-1:0]  clr_addr,
  output logic [NUM_REG-1:0] pending
);

  logic [NUM_REG-1:0] pending_next;

  // Clear first so a new producer in the same cycle supersedes the retiring one.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_addr] = 1'b0;
    if (set_en) pending_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

endmodule

// File: rtl/reg_file.sv
// Multi-read-port register file with same-cycle write forwarding and a
// pending-producer scoreboard reported per read port.
module reg_file
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_REG    = DEFAULT_NUM_REG,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic     clk,
  input  logic     rst,
  reg_file_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_REG);

  logic                           write_en;
  logic                           reserve_en;
  logic [ADDR_W-1:0]              port_addr;
  logic                           bypass_hit;
  logic                           reserve_hit;
  logic [NUM_REG-1:0]             pending;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ-1:0]            read_busy;
  logic [DATA_WIDTH-1:0]          regs [NUM_REG];

  // Register 0 is hardwired when ZERO_REG is set: drop its writes and reservations.
  assign write_en   = bus.i_write_enable &
                      ~((ZERO_REG != 0) && (bus.i_write_addr == '0));
  assign reserve_en = bus.i_reserve_enable &
                      ~((ZERO_REG != 0) && (bus.i_reserve_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REG); i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[bus.i_write_addr] <= bus.i_write_data;
    end
  end

  rf_scoreboard #(
    .NUM_REG (NUM_REG),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (reserve_en),
    .set_addr (bus.i_reserve_addr),
    .clr_en   (write_en),
    .clr_addr (bus.i_write_addr),
    .pending  (pending)
  );

  // Read muxes; a forwarded write also resolves busy unless re-reserved this cycle.
  always_comb begin
    read_data   = '0;
    read_busy   = '0;
    port_addr   = '0;
    bypass_hit  = 1'b0;
    reserve_hit = 1'b0;
    for (int p = 0; p < int'(NUM_READ); p++) begin
      port_addr   = bus.i_read_addr[p*ADDR_W +: ADDR_W];
      bypass_hit  = (BYPASS != 0) && write_en && (bus.i_write_addr == port_addr);
      reserve_hit = reserve_en && (bus.i_reserve_addr == port_addr);
      if ((ZERO_REG != 0) && (port_addr == '0))
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (bypass_hit)
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = bus.i_write_data;
      else
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[port_addr];
      read_busy[p] = pending[port_addr] & ~(bypass_hit & ~reserve_hit);
    end
  end

  assign bus.o_read_data = read_data;
  assign bus.o_read_busy = read_busy;
  assign bus.o_pending   = pending;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one forwarding and one non-forwarding instance
// driven in lockstep so forwarded and pre-edge read values can be compared.
module tb_reg_file;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  reg_file_if #(.DATA_WIDTH(DW), .NUM_REG(NR), .NUM_READ(NRD)) if_b ();
  reg_file_if #(.DATA_WIDTH(DW), .NUM_REG(NR), .NUM_READ(NRD)) if_n ();

  reg_file #(.DATA_WIDTH(DW), .NUM_REG(NR), .NUM_READ(NRD),
             .ZERO_REG(1), .BYPASS(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  reg_file #(.DATA_WIDTH(DW), .NUM_REG(NR), .NUM_READ(NRD),
             .ZERO_REG(1), .BYPASS(0)) dut_n (.clk(clk), .rst(rst), .bus(if_n));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] a0, input logic [4:0] a1);
    if_b.i_write_enable   = we;  if_n.i_write_enable   = we;
    if_b.i_write_addr     = wa;  if_n.i_write_addr     = wa;
    if_b.i_write_data     = wd;  if_n.i_write_data     = wd;
    if_b.i_reserve_enable = re;  if_n.i_reserve_enable = re;
    if_b.i_reserve_addr   = ra;  if_n.i_reserve_addr   = ra;
    if_b.i_read_addr      = {a1, a0};
    if_n.i_read_addr      = {a1, a0};
  endtask

  function automatic logic [63:0] rd(input logic [63:0] bus_data, input int p);
    return 64'(bus_data[p*32 +: 32]);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 5'd5, 5'd5);
    @(negedge clk); #1;
    check("rst_pending", 64'(if_b.o_pending), 64'h0);
    check("rst_data",    64'(if_b.o_read_data), 64'h0);
    check("rst_busy",    64'(if_b.o_read_busy), 64'h0);

    // r5 = DEADBEEF, read back on both ports
    @(negedge clk); rst = 1'b0;
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd5);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd5, 5'd5); #1;
    check("r5_p0", rd(64'(if_b.o_read_data), 0), 64'hDEADBEEF);
    check("r5_p1", rd(64'(if_b.o_read_data), 1), 64'hDEADBEEF);
    check("r5_p1_nobyp", rd(64'(if_n.o_read_data), 1), 64'hDEADBEEF);
    check("r5_busy", 64'(if_b.o_read_busy), 64'h0);

    // r0 hardwired: write and reservation ignored, no forwarding
    drive(1, 5'd0, 32'h12345678, 1, 5'd0, 5'd0, 5'd0); #1;
    check("r0_byp", rd(64'(if_b.o_read_data), 0), 64'h0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd0, 5'd0); #1;
    check("r0_data", rd(64'(if_b.o_read_data), 1), 64'h0);
    check("r0_pend", 64'(if_b.o_pending[0]), 64'h0);

    // r7: old value then forwarded write
    drive(1, 5'd7, 32'h11111111, 0, 0, 5'd5, 5'd7);
    @(negedge clk); drive(1, 5'd7, 32'hA5A5A5A5, 0, 0, 5'd5, 5'd7); #1;
    check("r7_byp",    rd(64'(if_b.o_read_data), 1), 64'hA5A5A5A5);
    check("r7_nobyp",  rd(64'(if_n.o_read_data), 1), 64'h11111111);
    check("r7_p0_r5",  rd(64'(if_b.o_read_data), 0), 64'hDEADBEEF);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd7, 5'd7); #1;
    check("r7_after",  rd(64'(if_n.o_read_data), 0), 64'hA5A5A5A5);

    // reserve r3, then resolve it with a write
    drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd3);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd3, 5'd3); #1;
    check("r3_pend",   64'(if_b.o_pending), 64'h8);
    check("r3_busy",   64'(if_b.o_read_busy), 64'h3);
    drive(1, 5'd3, 32'h55, 0, 0, 5'd3, 5'd3); #1;
    check("r3_wr_busy_byp",   64'(if_b.o_read_busy), 64'h0);
    check("r3_wr_busy_nobyp", 64'(if_n.o_read_busy), 64'h3);
    check("r3_wr_data_byp",   rd(64'(if_b.o_read_data), 0), 64'h55);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd3, 5'd3); #1;
    check("r3_clr_pend", 64'(if_n.o_pending), 64'h0);
    check("r3_data",     rd(64'(if_n.o_read_data), 1), 64'h55);

    // same-cycle reserve and write on r9: reservation wins
    drive(1, 5'd9, 32'h77, 1, 5'd9, 5'd9, 5'd9);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd9, 5'd9); #1;
    check("r9_data", rd(64'(if_b.o_read_data), 0), 64'h77);
    check("r9_pend", 64'(if_b.o_pending), 64'h200);
    check("r9_busy", 64'(if_b.o_read_busy), 64'h3);
    drive(1, 5'd9, 32'h88, 1, 5'd9, 5'd9, 5'd9); #1;
    check("r9_rewr_busy", 64'(if_b.o_read_busy), 64'h3);
    check("r9_rewr_data", rd(64'(if_b.o_read_data), 1), 64'h88);
    @(negedge clk); drive(0, 0, 0, 1, 5'd9, 5'd9, 5'd9);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd9, 5'd9); #1;
    check("r9_double_res", 64'(if_b.o_pending), 64'h200);
    drive(1, 5'd9, 32'h99, 0, 0, 5'd9, 5'd9);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd9, 5'd9); #1;
    check("r9_single_clr", 64'(if_b.o_pending), 64'h0);

    // reserve r4, write r6, then async reset between edges
    drive(1, 5'd6, 32'h1, 1, 5'd4, 5'd6, 5'd4);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd6, 5'd4); #1;
    check("r4_pend", 64'(if_b.o_pending), 64'h10);
    check("r6_data", rd(64'(if_b.o_read_data), 0), 64'h1);
    #1 rst = 1'b1; #1;
    check("arst_pend", 64'(if_b.o_pending), 64'h0);
    check("arst_r6",   rd(64'(if_b.o_read_data), 0), 64'h0);
    check("arst_busy", 64'(if_b.o_read_busy), 64'h0);

    // activity during reset is dropped except the forwarding path
    @(negedge clk); drive(1, 5'd10, 32'hBEEF, 1, 5'd11, 5'd10, 5'd11); #1;
    check("rst_byp",   rd(64'(if_b.o_read_data), 0), 64'hBEEF);
    check("rst_nobyp", rd(64'(if_n.o_read_data), 0), 64'h0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 5'd10, 5'd11); rst = 1'b0; #1;
    check("post_rst_r10",  rd(64'(if_b.o_read_data), 0), 64'h0);
    check("post_rst_pend", 64'(if_b.o_pending), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
